flag_register: RTL and testbench
================================

# flag_register

Produces and holds the NZCV condition flags consumed by the execute-stage condition check. Each cycle it derives candidate flags from the ALU result, carry and overflow. It commits selected flag groups only when the instruction is valid, not stalled or flushed, and passes its own condition. It also keeps a one-deep shadow copy for exception entry/return. Its packed `Flags` output is the flags input of the condition checker.

## Interface
Parameters:
- `WIDTH`, 32, ALU result width (≥2).

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `en`  in  1  pipeline advance; 0 = stall, no state changes except reset.
- `flush`  in  1  squash current instruction; blocks flag update, not save/restore.
- `valid_i`  in  1  execute-stage instruction valid.
- `CondEx`  in  1  current instruction's condition passed.
- `FlagW`  in  2  bit1 = update N,Z; bit0 = update C (and V if arithmetic).
- `AluArith`  in  1  1 = arithmetic op, 0 = logical/move op.
- `Result`  in  WIDTH  ALU result.
- `CarryOut`  in  1  adder carry (arithmetic ops).
- `ShiftCarry`  in  1  shifter carry-out (logical ops).
- `OverflowOut`  in  1  adder signed overflow.
- `save`  in  1  capture committed flags into shadow.
- `restore`  in  1  load committed flags from shadow.
- `Flags`  out  4  committed flags `{N,Z,C,V}`; reset 4'b0000.
- `FlagsSaved`  out  4  shadow copy; reset 4'b0000.
- `FlagsWritten`  out  1  registered pulse: a flag update committed last edge; reset 0.

## Operation
- Candidate flags, combinational:
  - N = `Result[WIDTH-1]`.
  - Z = (`Result` == 0).
  - C = `AluArith ? CarryOut : ShiftCarry`.
  - V = `OverflowOut`.
- Update qualifier `upd` = `valid_i & en & ~flush & CondEx`.
- On the edge, when `upd`:
  - `FlagW[1]` loads N and Z.
  - `FlagW[0]` loads C.
  - `FlagW[0] & AluArith` loads V. Logical ops never modify V.
  - Unselected bits hold.
- `restore & en` loads `Flags` from the shadow. This overrides any update in the same cycle.
- `save & en` loads the shadow from the pre-edge `Flags` value.
  - With a same-cycle update, the shadow gets the old flags.
  - With a same-cycle restore, the two registers swap.
- `FlagsWritten` next = `upd & (FlagW != 0) & ~(restore & en)`.
- Priority: `reset` > `en`=0 (hold all) > `restore` > update. `flush` only gates the update.

## Timing
- Write latency 1 cycle: the instruction at edge k is visible on `Flags` after edge k. The next instruction's condition check sees it with no bubble.
- No combinational path from any input to `Flags` or `FlagsSaved`.
- The candidate-flag logic sits in the cycle's ALU path. Its budget is the zero-detect reduction.
- Stall: with `en`=0 every register holds, including `FlagsWritten`.
- Asserting `reset` mid-stream clears `Flags`, `FlagsSaved` and `FlagsWritten` asynchronously. The first update is taken at the first edge after deassertion.
- Boundary values:
  - `Result` = 0 gives Z=1, N=0.
  - `Result` = 2^(WIDTH-1) gives N=1, Z=0.
  - All-ones gives N=1, Z=0.

## Structure
- Shared package `flag_pkg`:
  - bit indices `FLAG_N`=3, `FLAG_Z`=2, `FLAG_C`=1, `FLAG_V`=0;
  - `FlagW` encodings `FW_NONE`=2'b00, `FW_NZ`=2'b10, `FW_ALL`=2'b11;
  - typedef `flags_t` = logic [3:0].
- The condition checker imports the same package.
- One combinational sub-module, `flag_gen`, is natural: inputs are `Result`, the carries, `OverflowOut` and `AluArith`; output is the candidate `flags_t`.
- `flag_register` holds the registers, qualifier and priority logic.

## Test plan
- Reset, then CMP-style update: `Result`=0, `CarryOut`=1, `OverflowOut`=0, `AluArith`=1, `FlagW`=11, all qualifiers 1 → `Flags`=4'b0110 after one edge, `FlagsWritten`=1 for one cycle.
- Logical op: start from `Flags`=4'b0001, `Result`=32'h8000_0000, `ShiftCarry`=1, `AluArith`=0, `FlagW`=11 → `Flags`=4'b1011 (V held).
- Gating: with `CondEx`=0, or `flush`=1, or `en`=0, or `valid_i`=0, and `FlagW`=11 → `Flags` unchanged, `FlagsWritten`=0. With `FlagW`=10 → only N and Z change.
- Save/restore: `Flags`=4'b1000, then `save` → `FlagsSaved`=4'b1000. Update to 4'b0100, then `restore` with a simultaneous update to 4'b0010 → `Flags`=4'b1000. Save and restore in the same cycle → swap.
- Reset mid-stream: assert `reset` between edges while `Flags`=4'b1111 → `Flags`, `FlagsSaved` and `FlagsWritten` read 0 before the next edge. Deassert → the next update commits normally.

Source files
------------

// File: rtl/flag_pkg.sv
// Shared NZCV definitions used by the flag register and the condition checker.
package flag_pkg;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [1:0] FW_NONE = 2'b00;
  localparam logic [1:0] FW_NZ   = 2'b10;
  localparam logic [1:0] FW_ALL  = 2'b11;

  typedef logic [3:0] flags_t;

endpackage

// File: rtl/flag_gen.sv
// Candidate NZCV flags derived combinationally from the ALU outputs.
module flag_gen
  import flag_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] Result,
  input  logic             CarryOut,
  input  logic             ShiftCarry,
  input  logic             OverflowOut,
  input  logic             AluArith,
  output flags_t           cand
);

  // Candidate flags; the zero-detect reduction is the critical path.
  always_comb begin
    cand         = 4'b0000;
    cand[FLAG_N] = Result[WIDTH-1];
    cand[FLAG_Z] = (Result == {WIDTH{1'b0}});
    if (AluArith) begin
      cand[FLAG_C] = CarryOut;
    end else begin
      cand[FLAG_C] = ShiftCarry;
    end
    cand[FLAG_V] = OverflowOut;
  end

endmodule

// File: rtl/flag_register.sv
// Committed NZCV flags with qualified per-group update and a one-deep shadow
// copy for exception entry/return.
module flag_register
  import flag_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic             valid_i,
  input  logic             CondEx,
  input  logic [1:0]       FlagW,
  input  logic             AluArith,
  input  logic [WIDTH-1:0] Result,
  input  logic             CarryOut,
  input  logic             ShiftCarry,
  input  logic             OverflowOut,
  input  logic             save,
  input  logic             restore,
  output logic [3:0]       Flags,
  output logic [3:0]       FlagsSaved,
  output logic             FlagsWritten
);

  flags_t cand_s;
  flags_t flags_r;
  flags_t saved_r;
  logic   written_r;
  flags_t flags_nxt_s;
  flags_t saved_nxt_s;
  logic   written_nxt_s;
  logic   upd_s;

  flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .Result      (Result),
    .CarryOut    (CarryOut),
    .ShiftCarry  (ShiftCarry),
    .OverflowOut (OverflowOut),
    .AluArith    (AluArith),
    .cand        (cand_s)
  );

  assign upd_s = valid_i & en & ~flush & CondEx;

  // Next-state selection: stall holds everything, restore beats update.
  always_comb begin
    flags_nxt_s   = flags_r;
    saved_nxt_s   = saved_r;
    written_nxt_s = written_r;
    if (en) begin
      if (save) begin
        saved_nxt_s = flags_r;
      end else begin
        saved_nxt_s = saved_r;
      end
      if (restore) begin
        flags_nxt_s = saved_r;
      end else if (upd_s) begin
        if (FlagW[1]) begin
          flags_nxt_s[FLAG_N] = cand_s[FLAG_N];
          flags_nxt_s[FLAG_Z] = cand_s[FLAG_Z];
        end else begin
          flags_nxt_s[FLAG_N] = flags_r[FLAG_N];
          flags_nxt_s[FLAG_Z] = flags_r[FLAG_Z];
        end
        if (FlagW[0]) begin
          flags_nxt_s[FLAG_C] = cand_s[FLAG_C];
        end else begin
          flags_nxt_s[FLAG_C] = flags_r[FLAG_C];
        end
        // Logical ops never touch V.
        if (FlagW[0] & AluArith) begin
          flags_nxt_s[FLAG_V] = cand_s[FLAG_V];
        end else begin
          flags_nxt_s[FLAG_V] = flags_r[FLAG_V];
        end
      end else begin
        flags_nxt_s = flags_r;
      end
      written_nxt_s = upd_s & (FlagW != FW_NONE) & ~restore;
    end else begin
      flags_nxt_s   = flags_r;
      saved_nxt_s   = saved_r;
      written_nxt_s = written_r;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_r   <= 4'b0000;
      saved_r   <= 4'b0000;
      written_r <= 1'b0;
    end else begin
      flags_r   <= flags_nxt_s;
      saved_r   <= saved_nxt_s;
      written_r <= written_nxt_s;
    end
  end

  assign Flags        = flags_r;
  assign FlagsSaved   = saved_r;
  assign FlagsWritten = written_r;

endmodule

// File: tb/tb_flag_register.sv
// Directed and randomized checks of flag_register against a behavioural NZCV model.
module tb_flag_register;
  import flag_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, en, flush, valid_i, CondEx, AluArith;
  logic         CarryOut, ShiftCarry, OverflowOut, save, restore;
  logic [1:0]   FlagW;
  logic [W-1:0] Result;
  logic [3:0]   Flags, FlagsSaved;
  logic         FlagsWritten;

  int total = 0;
  int bad   = 0;

  logic [3:0] m_flags   = 4'b0000;
  logic [3:0] m_saved   = 4'b0000;
  logic       m_written = 1'b0;

  flag_register #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .flush        (flush),
    .valid_i      (valid_i),
    .CondEx       (CondEx),
    .FlagW        (FlagW),
    .AluArith     (AluArith),
    .Result       (Result),
    .CarryOut     (CarryOut),
    .ShiftCarry   (ShiftCarry),
    .OverflowOut  (OverflowOut),
    .save         (save),
    .restore      (restore),
    .Flags        (Flags),
    .FlagsSaved   (FlagsSaved),
    .FlagsWritten (FlagsWritten)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic c, input logic fl, input logic e,
                       input logic [1:0] fw, input logic ar, input logic [W-1:0] res,
                       input logic co, input logic sc, input logic ov,
                       input logic sv, input logic rs);
    valid_i = v; CondEx = c; flush = fl; en = e; FlagW = fw; AluArith = ar;
    Result = res; CarryOut = co; ShiftCarry = sc; OverflowOut = ov;
    save = sv; restore = rs;
  endtask

  // Reference: what one rising edge should do to the architectural flag state.
  task automatic step(input string tag);
    logic [3:0] nf, ns;
    logic       nw, n, z, c, upd;
    nf = m_flags; ns = m_saved; nw = m_written;
    if (en) begin
      n   = (Result >= {1'b1, {(W-1){1'b0}}});
      z   = (Result == 0);
      c   = AluArith ? CarryOut : ShiftCarry;
      upd = valid_i && !flush && CondEx;
      if (save) ns = m_flags;
      if (restore) nf = m_saved;
      else if (upd) begin
        if (FlagW[1]) begin nf[3] = n; nf[2] = z; end
        if (FlagW[0]) begin nf[1] = c; if (AluArith) nf[0] = OverflowOut; end
      end
      nw = upd && (FlagW != 2'b00) && !restore;
    end
    m_flags = nf; m_saved = ns; m_written = nw;
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".flags"}, Flags, m_flags);
    chk({tag, ".saved"}, FlagsSaved, m_saved);
    chk({tag, ".written"}, {3'b000, FlagsWritten}, {3'b000, m_written});
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b1, FW_NONE, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic mid_reset(input string tag);
    #2 reset = 1'b1;
    m_flags = 4'b0000; m_saved = 4'b0000; m_written = 1'b0;
    #1;
    chk({tag, ".rst_flags"}, Flags, 4'b0000);
    chk({tag, ".rst_saved"}, FlagsSaved, 4'b0000);
    chk({tag, ".rst_written"}, {3'b000, FlagsWritten}, 4'b0000);
    #1 reset = 1'b0;
  endtask

  initial begin
    logic [W-1:0] res;
    reset = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    chk("reset.flags", Flags, 4'b0000);
    chk("reset.saved", FlagsSaved, 4'b0000);
    chk("reset.written", {3'b000, FlagsWritten}, 4'b0000);
    reset = 1'b0;

    // CMP-style update with zero result.
    drive(1'b1, 1'b1, 1'b0, 1'b1, FW_ALL, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("cmp");
    chk("cmp.lit", Flags, 4'b0110);
    chk("cmp.pulse", {3'b000, FlagsWritten}, 4'b0001);
    idle(); step("cmp_after");

    // Logical op keeps V.
    drive(1'b1, 1'b1, 1'b0, 1'b1, FW_ALL, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("setv");
    chk("setv.lit", Flags, 4'b0001);
    drive(1'b1, 1'b1, 1'b0, 1'b1, FW_ALL, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("logic");
    chk("logic.lit", Flags, 4'b1011);

    // Gating: each blocker alone suppresses a full update.
    drive(1'b1, 1'b0, 1'b0, 1'b1, FW_ALL, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("gate_cond"); chk("gate_cond.lit", Flags, 4'b1011);
    drive(1'b1, 1'b1, 1'b1, 1'b1, FW_ALL, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("gate_flush"); chk("gate_flush.lit", Flags, 4'b1011);
    drive(1'b1, 1'b1, 1'b0, 1'b0, FW_ALL, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("gate_en"); chk("gate_en.lit", Flags, 4'b1011);
    drive(1'b0, 1'b1, 1'b0, 1'b1, FW_ALL, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("gate_valid"); chk("gate_valid.lit", Flags, 4'b1011);
    chk("gate_valid.pulse", {3'b000, FlagsWritten}, 4'b0000);
    drive(1'b1, 1'b1, 1'b0, 1'b1, FW_NZ, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("nz_only"); chk("nz_only.lit", Flags, 4'b0111);

    // Save / restore.
    drive(1'b1, 1'b1, 1'b0, 1'b1, FW_ALL, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("sr_set"); chk("sr_set.lit", Flags, 4'b1000);
    idle(); save = 1'b1;
    step("save"); chk("save.lit", FlagsSaved, 4'b1000);
    drive(1'b1, 1'b1, 1'b0, 1'b1, FW_ALL, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("sr_upd"); chk("sr_upd.lit", Flags, 4'b0100);
    drive(1'b1, 1'b1, 1'b0, 1'b1, FW_ALL, 1'b1, 32'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step("restore"); chk("restore.lit", Flags, 4'b1000);
    chk("restore.pulse", {3'b000, FlagsWritten}, 4'b0000);
    drive(1'b1, 1'b1, 1'b0, 1'b1, FW_ALL, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("pre_swap");
    idle(); save = 1'b1; restore = 1'b1;
    step("swap");
    chk("swap.flags_lit", Flags, 4'b1000);
    chk("swap.saved_lit", FlagsSaved, 4'b0100);

    // All-ones result, then asynchronous reset mid-cycle.
    drive(1'b1, 1'b1, 1'b0, 1'b1, FW_ALL, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step("ones"); chk("ones.lit", Flags, 4'b1011);
    idle();
    mid_reset("mid");
    drive(1'b1, 1'b1, 1'b0, 1'b1, FW_ALL, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("post_rst"); chk("post_rst.lit", Flags, 4'b0110);

    // Randomized traffic with boundary-biased results.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(3, 0))
        0: res = 32'h0000_0000;
        1: res = 32'h8000_0000;
        2: res = 32'hFFFF_FFFF;
        default: res = $urandom;
      endcase
      drive($urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0, $urandom_range(7, 0) == 0,
            $urandom_range(7, 0) != 0, 2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)), res,
            1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
            $urandom_range(7, 0) == 0, $urandom_range(7, 0) == 0);
      if ($urandom_range(49, 0) == 0) begin
        mid_reset("rnd");
      end
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
